// File: rtl/mem_pkg.sv
// Shared types for the memories library: read-during-write modes and the
// states of the post-reset init sequencer.
package mem_pkg;

  // What the output register shows when a write hits the port.
  typedef enum logic [1:0] {
    RW_READ_FIRST,
    RW_WRITE_FIRST,
    RW_NO_CHANGE
  } rw_mode_t;

  // INIT clears the array after reset; RUN accepts traffic.
  typedef enum logic {
    INIT,
    RUN
  } init_state_t;

  // Even-parity bit of one byte (1 when the byte holds an odd number of ones).
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sync_single_port_ram_if.sv
// Request/response bundle of the single-port RAM.
// Optional feature macro: SPRAM_PARITY_EN adds perr_inj and perr.
interface sync_single_port_ram_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
);
  localparam int ADDR_BUS = $clog2(DEPTH);
  localparam int NB       = WIDTH / 8;

  logic                en;
  logic                we;
  logic [NB-1:0]       be;
  logic [ADDR_BUS-1:0] addr;
  logic [WIDTH-1:0]    din;
  logic [WIDTH-1:0]    dout;
  logic                rvalid;
  logic                ready;
`ifdef SPRAM_PARITY_EN
  logic                perr_inj;
  logic [NB-1:0]       perr;

  modport master (output en, we, be, addr, din, perr_inj,
                  input  dout, rvalid, ready, perr);
  modport slave  (input  en, we, be, addr, din, perr_inj,
                  output dout, rvalid, ready, perr);
`else
  modport master (output en, we, be, addr, din,
                  input  dout, rvalid, ready);
  modport slave  (input  en, we, be, addr, din,
                  output dout, rvalid, ready);
`endif

endinterface

// File: rtl/spram_init_seq.sv
// Post-reset init sequencer: walks every address once writing the init word,
// then raises ready and stays in RUN until the next reset.
module spram_init_seq
  import mem_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int ADDR_BUS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_we,
  output logic [ADDR_BUS-1:0] init_addr,
  output logic                ready
);

  localparam logic [ADDR_BUS-1:0] LAST_ADDR = ADDR_BUS'(DEPTH - 1);

  init_state_t         state_reg, state_next;
  logic [ADDR_BUS-1:0] cnt_reg, cnt_next;

  // State and counter registers; reset restarts a full init.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state: one init write per cycle, leave INIT after the last address.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    init_we    = 1'b0;
    ready      = 1'b0;
    case (state_reg)
      INIT: begin
        init_we = 1'b1;
        if (cnt_reg == LAST_ADDR) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + ADDR_BUS'(1);
        end
      end
      RUN: ready = 1'b1;
      default: state_next = INIT;
    endcase
  end

  assign init_addr = cnt_reg;

endmodule

// File: rtl/sync_single_port_ram.sv
// Synchronous single-port RAM with byte enables, selectable read-during-write
// behaviour, registered output and hardware clear after reset.
// Optional feature macro: SPRAM_PARITY_EN stores one even-parity bit per byte.
module sync_single_port_ram
  import mem_pkg::*;
#(
  parameter int               WIDTH    = 32,  // multiple of 8
  parameter int               DEPTH    = 64,  // >= 2, any value
  parameter rw_mode_t         RW_MODE  = RW_READ_FIRST,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input logic                   clk,
  input logic                   rst,
  sync_single_port_ram_if.slave bus
);

  localparam int ADDR_BUS = $clog2(DEPTH);
  localparam int NB       = WIDTH / 8;
  // Depth widened by one bit so addresses past the end compare correctly.
  localparam logic [ADDR_BUS:0] DEPTH_W = (ADDR_BUS + 1)'(DEPTH);

  logic                init_we;
  logic [ADDR_BUS-1:0] init_addr;
  logic                ready;

  spram_init_seq #(
    .DEPTH    (DEPTH),
    .ADDR_BUS (ADDR_BUS)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .init_we   (init_we),
    .init_addr (init_addr),
    .ready     (ready)
  );

  logic [WIDTH-1:0] mem [DEPTH];

  logic             acc;
  logic             addr_ok;
  logic             wr_hit;
  logic [WIDTH-1:0] old_word;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] merged_word;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic             rvalid_reg, rvalid_next;

  assign acc      = ready & bus.en;
  assign addr_ok  = {1'b0, bus.addr} < DEPTH_W;
  assign wr_hit   = acc & bus.we & addr_ok;
  assign old_word = mem[bus.addr];
  // Out-of-range addresses read as zero.
  assign rd_word  = addr_ok ? old_word : '0;

  // Word as it will look after the write: new bytes where enabled.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign merged_word[gi*8 +: 8] = bus.be[gi] ? bus.din[gi*8 +: 8] : old_word[gi*8 +: 8];
    end
  endgenerate

`ifdef SPRAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] old_par, init_par, merged_par, rd_perr, wf_perr;
  logic [NB-1:0] perr_reg, perr_next;

  assign old_par = par_mem[bus.addr];

  // Per-lane parity: stored bit, bit after this write, and mismatch flags.
  generate
    for (gi = 0; gi < NB; gi++) begin : g_par
      assign init_par[gi]   = byte_par(INIT_VAL[gi*8 +: 8]);
      assign merged_par[gi] = bus.be[gi] ? (byte_par(bus.din[gi*8 +: 8]) ^ bus.perr_inj)
                                         : old_par[gi];
      assign rd_perr[gi]    = byte_par(old_word[gi*8 +: 8]) ^ old_par[gi];
      // A freshly written lane mismatches exactly when parity was injected.
      assign wf_perr[gi]    = bus.be[gi] ? bus.perr_inj : rd_perr[gi];
    end
  endgenerate
`endif

  // Array write port: init sequencer has the port until ready, then requests.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= INIT_VAL;
`ifdef SPRAM_PARITY_EN
      par_mem[init_addr] <= init_par;
`endif
    end else if (wr_hit) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.be[k]) mem[bus.addr][k*8 +: 8] <= bus.din[k*8 +: 8];
      end
`ifdef SPRAM_PARITY_EN
      par_mem[bus.addr] <= merged_par;
`endif
    end
  end

  // Output selection: reads return the stored word, writes follow RW_MODE.
  always_comb begin
    dout_next   = dout_reg;
    rvalid_next = 1'b0;
`ifdef SPRAM_PARITY_EN
    perr_next   = '0;
`endif
    if (acc) begin
      if (!bus.we) begin
        dout_next   = rd_word;
        rvalid_next = 1'b1;
`ifdef SPRAM_PARITY_EN
        perr_next   = addr_ok ? rd_perr : '0;
`endif
      end else begin
        case (RW_MODE)
          RW_READ_FIRST: begin
            dout_next   = rd_word;
            rvalid_next = 1'b1;
`ifdef SPRAM_PARITY_EN
            perr_next   = addr_ok ? rd_perr : '0;
`endif
          end
          RW_WRITE_FIRST: begin
            dout_next   = addr_ok ? merged_word : '0;
            rvalid_next = 1'b1;
`ifdef SPRAM_PARITY_EN
            perr_next   = addr_ok ? wf_perr : '0;
`endif
          end
          default: ;  // no-change: output holds, no valid pulse
        endcase
      end
    end
  end

  // Registered output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_reg   <= '0;
      rvalid_reg <= 1'b0;
`ifdef SPRAM_PARITY_EN
      perr_reg   <= '0;
`endif
    end else begin
      dout_reg   <= dout_next;
      rvalid_reg <= rvalid_next;
`ifdef SPRAM_PARITY_EN
      perr_reg   <= perr_next;
`endif
    end
  end

  assign bus.dout   = dout_reg;
  assign bus.rvalid = rvalid_reg;
  assign bus.ready  = ready;
`ifdef SPRAM_PARITY_EN
  assign bus.perr   = perr_reg;
`endif

endmodule

// File: tb/tb_sync_single_port_ram.sv
// Bench for sync_single_port_ram: three 16-deep instances (one per RW mode)
// and one 12-deep instance share the same stimulus and are compared against a
// per-instance word-level reference model.
module tb_sync_single_port_ram;
  import mem_pkg::*;

  localparam logic [31:0] IV = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, we = 1'b0, inj = 1'b0;
  logic [3:0]  be = '0, addr = '0;
  logic [31:0] din = '0;

  always #5 clk = ~clk;

  sync_single_port_ram_if #(.WIDTH(32), .DEPTH(16)) b0 ();
  sync_single_port_ram_if #(.WIDTH(32), .DEPTH(16)) b1 ();
  sync_single_port_ram_if #(.WIDTH(32), .DEPTH(16)) b2 ();
  sync_single_port_ram_if #(.WIDTH(32), .DEPTH(12)) b3 ();

  assign b0.en = en;   assign b1.en = en;   assign b2.en = en;   assign b3.en = en;
  assign b0.we = we;   assign b1.we = we;   assign b2.we = we;   assign b3.we = we;
  assign b0.be = be;   assign b1.be = be;   assign b2.be = be;   assign b3.be = be;
  assign b0.addr = addr; assign b1.addr = addr; assign b2.addr = addr; assign b3.addr = addr;
  assign b0.din = din; assign b1.din = din; assign b2.din = din; assign b3.din = din;

  logic [31:0] od  [4];
  logic        orv [4];
  logic        ordy[4];
  assign od[0] = b0.dout;  assign od[1] = b1.dout;  assign od[2] = b2.dout;  assign od[3] = b3.dout;
  assign orv[0] = b0.rvalid; assign orv[1] = b1.rvalid; assign orv[2] = b2.rvalid; assign orv[3] = b3.rvalid;
  assign ordy[0] = b0.ready; assign ordy[1] = b1.ready; assign ordy[2] = b2.ready; assign ordy[3] = b3.ready;

`ifdef SPRAM_PARITY_EN
  logic [3:0] operr[4];
  assign b0.perr_inj = inj; assign b1.perr_inj = inj; assign b2.perr_inj = inj; assign b3.perr_inj = inj;
  assign operr[0] = b0.perr; assign operr[1] = b1.perr; assign operr[2] = b2.perr; assign operr[3] = b3.perr;
`endif

  sync_single_port_ram #(.WIDTH(32), .DEPTH(16), .RW_MODE(RW_READ_FIRST),  .INIT_VAL(IV))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  sync_single_port_ram #(.WIDTH(32), .DEPTH(16), .RW_MODE(RW_WRITE_FIRST), .INIT_VAL(IV))
    dut1 (.clk(clk), .rst(rst), .bus(b1));
  sync_single_port_ram #(.WIDTH(32), .DEPTH(16), .RW_MODE(RW_NO_CHANGE),   .INIT_VAL(IV))
    dut2 (.clk(clk), .rst(rst), .bus(b2));
  sync_single_port_ram #(.WIDTH(32), .DEPTH(12), .RW_MODE(RW_READ_FIRST),  .INIT_VAL(IV))
    dut3 (.clk(clk), .rst(rst), .bus(b3));

  // Reference model state, one slot per instance.
  int       dep[4] = '{16, 16, 16, 12};
  rw_mode_t md [4] = '{RW_READ_FIRST, RW_WRITE_FIRST, RW_NO_CHANGE, RW_READ_FIRST};
  logic [31:0] mm[4][16];   // stored words
  logic [3:0]  mp[4][16];   // per-byte "parity corrupted" flags
  logic [31:0] ed[4];
  logic        erv[4];
  logic [3:0]  ep[4];
  int          edges;       // rising edges since reset release

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      ed[n]  = '0;
      erv[n] = 1'b0;
      ep[n]  = '0;
    end
    edges = 0;
  endtask

  // One accepted request against instance n's model.
  task automatic model_access(input int n, input logic w, input logic [3:0] b,
                              input logic [3:0] a, input logic [31:0] d, input logic i);
    bit          inr;
    logic [31:0] old, merged;
    logic [3:0]  oldp, mergedp;
    inr     = int'(a) < dep[n];
    old     = inr ? mm[n][a] : 32'h0;
    oldp    = inr ? mp[n][a] : 4'h0;
    merged  = old;
    mergedp = oldp;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) begin
        merged[k*8 +: 8] = d[k*8 +: 8];
        mergedp[k]       = i;
      end
    end
    if (!w) begin
      ed[n] = old; erv[n] = 1'b1; ep[n] = oldp;
    end else begin
      if (inr) begin
        mm[n][a] = merged;
        mp[n][a] = mergedp;
      end
      if (md[n] == RW_READ_FIRST) begin
        ed[n] = old; erv[n] = 1'b1; ep[n] = oldp;
      end else if (md[n] == RW_WRITE_FIRST) begin
        ed[n] = inr ? merged : 32'h0; erv[n] = 1'b1; ep[n] = inr ? mergedp : 4'h0;
      end else begin
        erv[n] = 1'b0; ep[n] = 4'h0;
      end
    end
  endtask

  // Drive one cycle of stimulus, advance the model, check all instances.
  task automatic step(input logic e, input logic w, input logic [3:0] b,
                      input logic [3:0] a, input logic [31:0] d, input logic i);
    en = e; we = w; be = b; addr = a; din = d; inj = i;
    @(posedge clk);
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        if (e && edges >= dep[n]) model_access(n, w, b, a, d, i);
        else begin erv[n] = 1'b0; ep[n] = 4'h0; end
      end
      edges++;
      for (int n = 0; n < 4; n++) begin
        if (edges == dep[n]) begin
          for (int j = 0; j < 16; j++) begin
            mm[n][j] = IV;
            mp[n][j] = 4'h0;
          end
        end
      end
    end
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("dout[%0d]", n),   od[n],   ed[n]);
      chk($sformatf("rvalid[%0d]", n), {31'h0, orv[n]},  {31'h0, erv[n]});
      chk($sformatf("ready[%0d]", n),  {31'h0, ordy[n]}, {31'h0, (rst && edges >= dep[n])});
`ifdef SPRAM_PARITY_EN
      chk($sformatf("perr[%0d]", n),   {28'h0, operr[n]}, {28'h0, ep[n]});
`endif
    end
    $display("txn rst=%0b en=%0b we=%0b be=%h addr=%0d din=%h | dout0=%h rv0=%0b rdy0=%0b dout3=%h",
             rst, e, w, b, a, d, od[0], orv[0], ordy[0], od[3]);
  endtask

  task automatic rnd_step();
    step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
         4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    model_reset();
    // Held in reset: everything idle and zero.
    repeat (3) step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);

    // Start an init, then reset again partway through (requests ignored).
    rst = 1'b1;
    repeat (7) rnd_step();
    rst = 1'b0;
    model_reset();
    repeat (2) rnd_step();
    rst = 1'b1;
    // Requests during init are ignored; ready rises exactly at edge DEPTH.
    repeat (17) rnd_step();

    // Every word of the 16-deep arrays holds the init value.
    for (int a = 0; a < 16; a++) begin
      step(1'b1, 1'b0, 4'h0, 4'(a), 32'h0, 1'b0);
      chk("init_word", od[0], IV);
    end

    // Byte-enable merge.
    step(1'b1, 1'b1, 4'b1111, 4'd5, 32'h11223344, 1'b0);
    step(1'b1, 1'b1, 4'b0101, 4'd5, 32'hAABBCCDD, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 4'd5, 32'h0, 1'b0);
    chk("be_merge", od[0], 32'h11BB33DD);

    // Read-during-write modes on a zeroed word.
    step(1'b1, 1'b1, 4'b1111, 4'd3, 32'h0, 1'b0);
    step(1'b1, 1'b1, 4'b1111, 4'd3, 32'hFFFFFFFF, 1'b0);
    chk("rf_dout", od[0], 32'h0);
    chk("rf_rvalid", {31'h0, orv[0]}, 32'h1);
    chk("wf_dout", od[1], 32'hFFFFFFFF);
    chk("wf_rvalid", {31'h0, orv[1]}, 32'h1);
    chk("nc_rvalid", {31'h0, orv[2]}, 32'h0);

    // Zero-enable write leaves memory alone.
    step(1'b1, 1'b1, 4'b0000, 4'd3, 32'h12345678, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 4'd3, 32'h0, 1'b0);
    chk("be0_keep", od[0], 32'hFFFFFFFF);

    // Past the end of the 12-deep instance: write dropped, read returns 0.
    step(1'b1, 1'b1, 4'b1111, 4'd13, 32'hCAFEF00D, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 4'd13, 32'h0, 1'b0);
    chk("oor_dout", od[3], 32'h0);
    chk("oor_rvalid", {31'h0, orv[3]}, 32'h1);
    chk("inr_dout", od[0], 32'hCAFEF00D);

    // Idle cycle: output holds, no valid pulse.
    step(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    chk("idle_hold", od[0], 32'hCAFEF00D);

`ifdef SPRAM_PARITY_EN
    // Injected parity on one lane is reported only on that lane.
    step(1'b1, 1'b1, 4'b0010, 4'd2, 32'h5A5A5A5A, 1'b1);
    step(1'b1, 1'b0, 4'b0000, 4'd2, 32'h0, 1'b0);
    chk("perr_inj", {28'h0, operr[0]}, 32'h2);
    step(1'b1, 1'b0, 4'b0000, 4'd1, 32'h0, 1'b0);
    chk("perr_clean", {28'h0, operr[0]}, 32'h0);
`endif

    // Random traffic against the model.
    repeat (200) rnd_step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_single_port_ram.md
# sync_single_port_ram

Parametrised synchronous single-port RAM: byte-enable writes, a configurable read-during-write mode, registered output, and a hardware init sequencer that clears the array after reset. It is the general-purpose storage macro for the memories library and replaces ad-hoc combinational-write arrays in new designs. Access is one request per cycle, with a fixed 1-cycle read latency and a `ready` flag gating all traffic.

## Interface
- `WIDTH`, 32, data word width; must be a multiple of 8.
- `DEPTH`, 64, number of words; any value ≥ 2 (power of two not required).
- `ADDR_BUS`, `$clog2(DEPTH)`, address width; derived, never overridden.
- `RW_MODE`, `RW_READ_FIRST`, read-during-write behaviour: `RW_READ_FIRST` / `RW_WRITE_FIRST` / `RW_NO_CHANGE`.
- `INIT_VAL`, `'0`, word written to every location by the init sequencer.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  access request, sampled only while `ready`=1.
- `we`  in  1  1 = write, 0 = read (qualified by `en`).
- `be`  in  WIDTH/8  byte enables for writes; bit k covers `din[8k+7:8k]`.
- `addr`  in  ADDR_BUS  word address.
- `din`  in  WIDTH  write data.
- `dout`  out  WIDTH  registered read data.
- `rvalid`  out  1  high for exactly one cycle when `dout` was updated by an access.
- `ready`  out  1  1 = init complete and accepting requests.

## Operation
- FSM states: `INIT`, `RUN`. While `rst`=0: state=`INIT`, init counter=0, `ready`=0, `dout`=0, `rvalid`=0. Array contents are not touched asynchronously.
- `INIT`: each cycle writes `INIT_VAL` to `mem[cnt]` and increments `cnt`. After the write to DEPTH-1: state→`RUN`, `ready`=1. `en` is ignored throughout `INIT`.
- Reset asserted mid-init: counter restarts at 0 and a full init runs again.
- `RUN`, `en`=1, `we`=0: `dout`←`mem[addr]`, `rvalid`=1.
- `RUN`, `en`=1, `we`=1: for each k with `be[k]`=1, byte k of `mem[addr]`←byte k of `din`. `dout` update per `RW_MODE`:
  - `RW_READ_FIRST`: `dout` = old word, `rvalid`=1.
  - `RW_WRITE_FIRST`: `dout` = merged word (new bytes where `be`=1, old bytes elsewhere), `rvalid`=1.
  - `RW_NO_CHANGE`: `dout` holds, `rvalid`=0.
- `we`=1 with `be`=0: memory unchanged; `dout` follows the mode rules above (the merged word equals the old word).
- `en`=0: `dout` holds its last value; `rvalid`=0.
- `addr` ≥ DEPTH (non-power-of-two DEPTH only): write dropped; a read returns 0 with `rvalid`=1.

## Timing
- Read latency: 1 cycle. Request sampled at edge N; `dout`/`rvalid` valid after edge N.
- Init latency: `ready` rises at rising edge DEPTH after `rst` deasserts (edges 1..DEPTH perform the writes). The first request is accepted at edge DEPTH+1.
- Back-to-back accesses sustain one per cycle. A write at edge N is visible to a read at edge N+1.
- `ready` stays high until the next reset. It never deasserts otherwise.

## Configuration
- `SPRAM_PARITY_EN` defined:
  - One even-parity bit is stored per byte, written alongside the data, including during init.
  - Adds input `perr_inj` (1 bit): when high on a write, the stored parity of the enabled bytes is inverted.
  - Adds output `perr` (WIDTH/8): registered with `dout`, bit k = parity mismatch on byte k. Reset value 0, and 0 whenever `rvalid`=0.
- `SPRAM_PARITY_EN` undefined: no parity storage, and the `perr_inj` and `perr` ports are absent.

## Structure
- Package `mem_pkg`: the `RW_READ_FIRST`/`RW_WRITE_FIRST`/`RW_NO_CHANGE` constants (an enum typedef `rw_mode_t`), and the `INIT`/`RUN` state typedef.
- One sub-module, `spram_init_seq`: the init counter and FSM, producing the write strobe, init address and `ready`. Array, muxing and output register stay in the top module.

## Test plan
- WIDTH=32, DEPTH=16, INIT_VAL=32'hDEADBEEF: release reset → `ready` rises at edge 16; reads of all 16 addresses return 32'hDEADBEEF.
- Write 32'h11223344 to addr 5, then write `be`=4'b0101 with `din`=32'hAABBCCDD to addr 5, then read addr 5 → 32'h11BB33DD.
- Write to addr 3 holding 32'h0 with `din`=32'hFFFFFFFF and `be`=4'b1111: READ_FIRST → `dout`=0, `rvalid`=1; WRITE_FIRST → `dout`=32'hFFFFFFFF, `rvalid`=1; NO_CHANGE → `dout` holds, `rvalid`=0.
- Assert `rst` at init cycle 7, release, and issue requests during init → requests ignored, `ready` rises 16 edges after release, and all words equal INIT_VAL.
- DEPTH=12: write to addr 13 is dropped; read of addr 13 → `dout`=0, `rvalid`=1.
- `SPRAM_PARITY_EN`: write addr 2 with `perr_inj`=1 and `be`=4'b0010, then read addr 2 → `perr`=4'b0010; read any clean address → `perr`=0.
